// File: rtl/core_out_drain.sv
// core_out_drain: drain stage for the core output bus.
// Each valid row from the core (col words of psum_bw bits) goes into a row FIFO.
// The head row is then sent out one column word per transfer over a
// valid/ready stream.
// Optional build macro OUT_RELU_EN: when it is defined, each output word is
// clamped to zero if it is negative. Stored rows keep their raw values.
module core_out_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [psum_bw*col-1:0]   in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [psum_bw-1:0]       out_data,
  output logic [$clog2(col)-1:0]   out_col,
  output logic                     out_last,
  output logic [$clog2(depth):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(col);

  localparam logic [CW-1:0] LAST_COL = CW'(col - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(depth);

  logic [psum_bw*col-1:0] r_mem [depth];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [CW-1:0]          r_col_idx;
  logic                   r_ovf;

  logic                   w_nonempty;
  logic                   w_xfer;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;
  logic                   w_drop;
  logic [psum_bw*col-1:0] w_head_row;
  logic [psum_bw-1:0]     w_word;
  logic [psum_bw-1:0]     w_word_out;

  // Handshake decode.
  // A row pops only when its last word is taken.
  // A full FIFO can still accept a row in the cycle that frees a slot.
  always_comb begin
    w_nonempty = (r_count != '0);
    w_xfer     = w_nonempty && out_ready;
    w_pop      = w_xfer && (r_col_idx == LAST_COL);
    w_full     = (r_count == FULL_CNT);
    w_push     = in_valid && (!w_full || w_pop);
    w_drop     = in_valid && !w_push;
  end

  // Row storage has no reset.
  // Stale contents are never visible, because the read side is gated by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy, column index and the sticky overflow flag.
  // A reset in the middle of a row discards everything, including the partial row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_col_idx <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_xfer) begin
        if (r_col_idx == LAST_COL) begin
          r_col_idx <= '0;
        end else begin
          r_col_idx <= r_col_idx + 1'b1;
        end
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Read side: select the current column of the head row.
  // Optionally clamp the word, then force zero when nothing is buffered.
  always_comb begin
    w_head_row = r_mem[r_rd_ptr];
    w_word     = w_head_row[int'(r_col_idx)*psum_bw +: psum_bw];
`ifdef OUT_RELU_EN
    w_word_out = w_word[psum_bw-1] ? '0 : w_word;
`else
    w_word_out = w_word;
`endif
    out_valid  = w_nonempty;
    out_data   = w_nonempty ? w_word_out : '0;
    out_col    = r_col_idx;
    out_last   = w_nonempty && (r_col_idx == LAST_COL);
    fifo_count = r_count;
    overflow   = r_ovf;
  end

endmodule

// File: tb/tb_core_out_drain.sv
// tb_core_out_drain: directed bench for core_out_drain with col=8, psum_bw=16, depth=16.
// Inputs change 1 time unit after a rising edge, and outputs are checked in that same window.
module tb_core_out_drain;

  localparam int COL   = 8;
  localparam int PBW   = 16;
  localparam int DEPTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [PBW*COL-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [PBW-1:0]   out_data;
  logic [2:0]       out_col;
  logic             out_last;
  logic [4:0]       fifo_count;
  logic             overflow;
  logic             clr_ovf;

  int nCompared;
  int nMismatched;

  core_out_drain #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit, so a hung design cannot stall the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Build a row whose word k is base+k. Column 0 sits in the low bits.
  function automatic logic [PBW*COL-1:0] makeRow(input logic [15:0] base);
    logic [PBW*COL-1:0] r;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      r[k*PBW +: PBW] = 16'(base + 16'(k));
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [PBW*COL-1:0] d,
                               input logic rdy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clr_ovf   = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [PBW*COL-1:0] row;
  logic [15:0]        wq[$];
  logic [15:0]        expWord;
  int                 pushes;
  int                 modelRows;
  int                 expCol;
  int                 cycles;
  bit                 rdy;
  bit                 doPush;

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #12;

    // Reset state.
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_ovf",   32'(overflow), 32'd0);
    checkOutput("rst_data",  32'(out_data), 32'd0);
    checkOutput("rst_col",   32'(out_col), 32'd0);
    checkOutput("rst_last",  32'(out_last), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Test 1: one row with words 1..8, drained with out_ready held high.
    applyStimulus(1'b1, makeRow(16'd1), 1'b0, 1'b0);
    checkOutput("t1_nobypass", 32'(out_valid), 32'd0);
    step();
    checkOutput("t1_count1", 32'(fifo_count), 32'd1);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < COL; k++) begin
      checkOutput("t1_data", 32'(out_data), 32'(k + 1));
      checkOutput("t1_col",  32'(out_col), 32'(k));
      checkOutput("t1_last", 32'(out_last), (k == COL - 1) ? 32'd1 : 32'd0);
      step();
    end
    checkOutput("t1_count0", 32'(fifo_count), 32'd0);
    checkOutput("t1_empty",  32'(out_valid), 32'd0);
    checkOutput("t1_zero",   32'(out_data), 32'd0);

    // Test 2: fill all 16 rows while stalled.
    // The 17th row must be dropped and set overflow; clr_ovf then clears it.
    for (int r = 0; r < DEPTH; r++) begin
      applyStimulus(1'b1, makeRow(16'(16'h1000 + r * 16)), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t2_full",   32'(fifo_count), 32'd16);
    checkOutput("t2_noovf",  32'(overflow), 32'd0);
    applyStimulus(1'b1, makeRow(16'hDE00), 1'b0, 1'b0);
    step();
    checkOutput("t2_ovf",    32'(overflow), 32'd1);
    checkOutput("t2_count",  32'(fifo_count), 32'd16);
    checkOutput("t2_head",   32'(out_data), 32'h1000);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t2_clr",    32'(overflow), 32'd0);

    // Test 3: move the head to column 7.
    // Then push and pop on the same edge while the FIFO is full.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < COL - 1; k++) step();
    checkOutput("t3_col7",   32'(out_col), 32'd7);
    checkOutput("t3_word7",  32'(out_data), 32'h1007);
    checkOutput("t3_last",   32'(out_last), 32'd1);
    applyStimulus(1'b1, makeRow(16'h1100), 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_count",  32'(fifo_count), 32'd16);
    checkOutput("t3_noovf",  32'(overflow), 32'd0);
    checkOutput("t3_col0",   32'(out_col), 32'd0);
    for (int r = 1; r <= DEPTH; r++) begin
      for (int k = 0; k < COL; k++) begin
        checkOutput("t3_drain", 32'(out_data), 32'(16'h1000 + r * 16 + k));
        step();
      end
    end
    checkOutput("t3_empty",  32'(fifo_count), 32'd0);

    // Test 4: 32 rows with random out_ready and random pushes.
    // The model tracks expected words, column and row count.
    pushes = 0;
    modelRows = 0;
    expCol = 0;
    cycles = 0;
    wq.delete();
    while (!(pushes == 32 && wq.size() == 0) && cycles < 3000) begin
      rdy    = 1'($urandom_range(0, 1));
      doPush = (pushes < 32) && ($urandom_range(0, 1) == 1) && (modelRows < DEPTH);
      row    = makeRow(16'(16'h2000 + pushes * 8));
      applyStimulus(doPush, row, rdy, 1'b0);
      checkOutput("t4_count", 32'(fifo_count), 32'(modelRows));
      checkOutput("t4_valid", 32'(out_valid), (modelRows != 0) ? 32'd1 : 32'd0);
      if (wq.size() > 0) begin
        checkOutput("t4_data", 32'(out_data), 32'(wq[0]));
        checkOutput("t4_col",  32'(out_col), 32'(expCol));
      end
      step();
      if (rdy && wq.size() > 0) begin
        expWord = wq.pop_front();
        if (expCol == COL - 1) begin
          expCol = 0;
          modelRows--;
        end else begin
          expCol++;
        end
      end
      if (doPush) begin
        for (int k = 0; k < COL; k++) wq.push_back(16'(16'h2000 + pushes * 8 + k));
        modelRows++;
        pushes++;
      end
      cycles++;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t4_done",  32'(pushes == 32 && wq.size() == 0), 32'd1);
    checkOutput("t4_noovf", 32'(overflow), 32'd0);
    checkOutput("t4_empty", 32'(fifo_count), 32'd0);

    // Test 5: assert reset asynchronously after 3 words of a row.
    applyStimulus(1'b1, makeRow(16'h3000), 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_col3",   32'(out_col), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_valid",  32'(out_valid), 32'd0);
    checkOutput("t5_count",  32'(fifo_count), 32'd0);
    checkOutput("t5_col",    32'(out_col), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, makeRow(16'h4000), 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_newcol",  32'(out_col), 32'd0);
    checkOutput("t5_newdata", 32'(out_data), 32'h4000);
    checkOutput("t5_newcnt",  32'(fifo_count), 32'd1);

    // Drain that row before the ReLU check.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < COL; k++) step();
    checkOutput("t5_drained", 32'(fifo_count), 32'd0);

    // Test 6: a negative word 0xFFF0 in column 2.
    row = makeRow(16'h0010);
    row[2*PBW +: PBW] = 16'hFFF0;
    applyStimulus(1'b1, row, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_col0", 32'(out_data), 32'h0010);
    step();
    checkOutput("t6_col1", 32'(out_data), 32'h0011);
    step();
    checkOutput("t6_colidx", 32'(out_col), 32'd2);
`ifdef OUT_RELU_EN
    checkOutput("t6_relu", 32'(out_data), 32'h0000);
`else
    checkOutput("t6_raw",  32'(out_data), 32'hFFF0);
`endif
    step();
    checkOutput("t6_col3", 32'(out_data), 32'h0013);
    for (int k = 3; k < COL; k++) step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6_empty", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
